// File: rtl/uart_tx_framer.sv
// uart_tx_framer: valid/ready UART transmitter, one word per frame on baud ticks
// Ports: i_CLK clock, i_RST_N async active-low reset, i_CLK_ENABLE one-cycle baud tick,
//        i_TX_VALID/i_DATA_IN/o_TX_READY word handshake, o_TX serial line (idle high),
//        o_BUSY frame pending or in progress, o_DONE pulse on the final stop-bit launch
module uart_tx_framer #(
    parameter int DATA_BITS   = 8,
    parameter int PARITY_MODE = 0,
    parameter int STOP_BITS   = 1
) (
    input  logic                 i_CLK,
    input  logic                 i_RST_N,
    input  logic                 i_CLK_ENABLE,
    input  logic                 i_TX_VALID,
    input  logic [DATA_BITS-1:0] i_DATA_IN,
    output logic                 o_TX_READY,
    output logic                 o_TX,
    output logic                 o_BUSY,
    output logic                 o_DONE
);
    typedef enum logic [2:0] {IDLE, WAIT_START, DATA, PARITY, STOP} state_t;
    localparam logic [3:0] LAST_DATA = 4'(DATA_BITS - 1);
    localparam logic [3:0] LAST_STOP = 4'(STOP_BITS - 1);
    state_t               state;
    logic [DATA_BITS-1:0] shift;
    logic [3:0]           cnt;
    logic                 par;
    generate
        if (DATA_BITS < 5 || DATA_BITS > 9 || STOP_BITS < 1 || STOP_BITS > 2 ||
            PARITY_MODE < 0 || PARITY_MODE > 2) begin : g_bad_params
            $error("uart_tx_framer: illegal DATA_BITS/PARITY_MODE/STOP_BITS");
        end
    endgenerate
    assign o_TX_READY = state == IDLE;
    assign o_BUSY     = state != IDLE;
    // Accept ignores the tick; every other transition waits for one, so a tick
    // coinciding with accept never shortens the start bit.
    always_ff @(posedge i_CLK or negedge i_RST_N) begin
        if (!i_RST_N) begin
            state  <= IDLE;
            o_TX   <= 1'b1;
            o_DONE <= 1'b0;
            cnt    <= '0;
            shift  <= '0;
            par    <= 1'b0;
        end else begin
            o_DONE <= 1'b0;
            case (state)
                IDLE: if (i_TX_VALID) begin
                    shift <= i_DATA_IN;
                    par   <= PARITY_MODE == 1 ? ~^i_DATA_IN : ^i_DATA_IN;
                    state <= WAIT_START;
                end
                WAIT_START: if (i_CLK_ENABLE) begin
                    o_TX  <= 1'b0;
                    cnt   <= '0;
                    state <= DATA;
                end
                DATA: if (i_CLK_ENABLE) begin
                    o_TX  <= shift[0];
                    shift <= shift >> 1;
                    cnt   <= cnt == LAST_DATA ? '0 : cnt + 4'd1;
                    if (cnt == LAST_DATA) state <= PARITY_MODE != 0 ? PARITY : STOP;
                end
                PARITY: if (i_CLK_ENABLE) begin
                    o_TX  <= par;
                    state <= STOP;
                end
                STOP: if (i_CLK_ENABLE) begin
                    o_TX <= 1'b1;
                    cnt  <= cnt == LAST_STOP ? '0 : cnt + 4'd1;
                    if (cnt == LAST_STOP) begin
                        o_DONE <= 1'b1;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_framer.sv
// tb_uart_tx_framer: scoreboard bench for 8N1, 7E2 and 8O1 framers sharing clock, tick and reset
module tb_uart_tx_framer;
    typedef struct {logic b; logic last;} exp_t;
    typedef struct {logic [7:0] data; logic [9:0] frame;} vec_t;

    logic       clk, rst_n, tick, tick_on;
    logic [2:0] valid, tx, ready, busy, done, launched;
    logic [7:0] d0, d2;
    logic [6:0] d1;
    int         div, compared, mismatched;
    exp_t       q[3][$];
    exp_t       e;
    vec_t       vecs[5];

    uart_tx_framer u0 (.i_CLK(clk), .i_RST_N(rst_n), .i_CLK_ENABLE(tick), .i_TX_VALID(valid[0]),
        .i_DATA_IN(d0), .o_TX_READY(ready[0]), .o_TX(tx[0]), .o_BUSY(busy[0]), .o_DONE(done[0]));
    uart_tx_framer #(.DATA_BITS(7), .PARITY_MODE(2), .STOP_BITS(2)) u1 (.i_CLK(clk), .i_RST_N(rst_n),
        .i_CLK_ENABLE(tick), .i_TX_VALID(valid[1]), .i_DATA_IN(d1), .o_TX_READY(ready[1]),
        .o_TX(tx[1]), .o_BUSY(busy[1]), .o_DONE(done[1]));
    uart_tx_framer #(.DATA_BITS(8), .PARITY_MODE(1), .STOP_BITS(1)) u2 (.i_CLK(clk), .i_RST_N(rst_n),
        .i_CLK_ENABLE(tick), .i_TX_VALID(valid[2]), .i_DATA_IN(d2), .o_TX_READY(ready[2]),
        .o_TX(tx[2]), .o_BUSY(busy[2]), .o_DONE(done[2]));

    initial clk = 0;
    always #5 clk = ~clk;

    initial begin
        tick = 0;
        div  = 0;
        forever begin
            @(negedge clk);
            div  = div == 3 ? 0 : div + 1;
            tick = tick_on && div == 0;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // A bit is launched on every tick edge where the framer was busy beforehand.
    always @(posedge clk) begin
        launched = busy & {3{tick}};
        #1;
        for (int k = 0; k < 3; k++) begin
            if (launched[k]) begin
                if (q[k].size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("FAIL unexpected_launch dut%0d: got tx=%b expected no bit", k, tx[k]);
                end else begin
                    e = q[k].pop_front();
                    chk($sformatf("bit_dut%0d", k), 32'(tx[k]), 32'(e.b));
                    chk($sformatf("done_dut%0d", k), 32'(done[k]), 32'(e.last));
                    if (e.last) chk($sformatf("ready_after_done_dut%0d", k), 32'(ready[k]), 1);
                end
            end else if (done[k]) begin
                compared++;
                mismatched++;
                $display("FAIL stray_done dut%0d: got 1 expected 0", k);
            end
        end
    end

    task automatic push_frame(input int k, input int db, input int pm, input int sb, input logic [8:0] d);
        int ones = 0;
        q[k].push_back('{1'b0, 1'b0});
        for (int i = 0; i < db; i++) begin
            q[k].push_back('{d[i], 1'b0});
            ones += int'(d[i]);
        end
        if (pm != 0) q[k].push_back('{pm == 1 ? ones % 2 == 0 : ones % 2 == 1, 1'b0});
        for (int s = 0; s < sb; s++) q[k].push_back('{1'b1, s == sb - 1});
    endtask

    task automatic wait_ready(input int k);
        int c = 0;
        while (ready[k] !== 1'b1 && c < 3000) begin
            @(negedge clk);
            c++;
        end
        if (c >= 3000) begin
            compared++;
            mismatched++;
            $display("FAIL ready_timeout dut%0d: got ready=%b expected 1", k, ready[k]);
        end
    endtask

    task automatic wait_idle(input int k);
        int c = 0;
        while ((q[k].size() != 0 || ready[k] !== 1'b1) && c < 3000) begin
            @(negedge clk);
            c++;
        end
        if (c >= 3000) begin
            compared++;
            mismatched++;
            $display("FAIL idle_timeout dut%0d: got %0d pending bits expected 0", k, q[k].size());
        end
    endtask

    task automatic send(input int k, input logic [8:0] d);
        wait_ready(k);
        valid[k] = 1;
        if (k == 0) d0 = d[7:0];
        if (k == 1) d1 = d[6:0];
        if (k == 2) d2 = d[7:0];
        @(negedge clk);
        valid[k] = 0;
        chk($sformatf("accept_ready_low_dut%0d", k), 32'(ready[k]), 0);
    endtask

    task automatic wait_ticks(input int n);
        repeat (n) @(posedge clk iff tick);
        #2;
    endtask

    initial begin
        logic held_tx;
        int   c;
        compared   = 0;
        mismatched = 0;
        rst_n      = 0;
        valid      = 0;
        tick_on    = 1;
        d0 = 0; d1 = 0; d2 = 0;
        vecs[0] = '{8'hA5, 10'b1_10100101_0};
        vecs[1] = '{8'h00, 10'b1_00000000_0};
        vecs[2] = '{8'hFF, 10'b1_11111111_0};
        vecs[3] = '{8'h5A, 10'b1_01011010_0};
        vecs[4] = '{8'h81, 10'b1_10000001_0};
        repeat (3) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("reset_tx_dut%0d", k), 32'(tx[k]), 1);
            chk($sformatf("reset_ready_dut%0d", k), 32'(ready[k]), 1);
            chk($sformatf("reset_busy_dut%0d", k), 32'(busy[k]), 0);
            chk($sformatf("reset_done_dut%0d", k), 32'(done[k]), 0);
        end
        rst_n = 1;
        @(negedge clk);

        for (int i = 0; i < 5; i++) begin
            for (int b = 0; b < 10; b++) q[0].push_back('{vecs[i].frame[b], b == 9});
            send(0, {1'b0, vecs[i].data});
            wait_idle(0);
        end

        push_frame(1, 7, 2, 2, 9'h41);
        send(1, 9'h41);
        push_frame(2, 8, 1, 1, 9'h00);
        send(2, 9'h00);
        wait_idle(1);
        wait_idle(2);
        push_frame(2, 8, 1, 1, 9'hFF);
        send(2, 9'hFF);
        push_frame(1, 7, 2, 2, 9'h2A);
        send(1, 9'h2A);
        wait_idle(2);
        wait_idle(1);

        push_frame(0, 8, 0, 1, 9'h55);
        push_frame(0, 8, 0, 1, 9'h0F);
        wait_ready(0);
        valid[0] = 1;
        d0 = 8'h55;
        c = 0;
        do begin @(negedge clk); c++; end while (ready[0] && c < 100);
        d0 = 8'h0F;
        c = 0;
        while (!done[0] && c < 200) begin @(negedge clk); c++; end
        chk("b2b_first_done_seen", 32'(done[0]), 1);
        chk("b2b_ready_at_done", 32'(ready[0]), 1);
        @(negedge clk);
        valid[0] = 0;
        chk("b2b_second_accept", 32'(ready[0]), 0);
        wait_ticks(1);
        chk("b2b_no_gap_start", 32'(tx[0]), 0);
        wait_idle(0);

        push_frame(0, 8, 0, 1, 9'h3C);
        send(0, 9'h3C);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            d0 = 8'($urandom);
            valid[0] = 1;
            @(negedge clk);
            valid[0] = 0;
            chk("ignore_while_busy", 32'(ready[0]), 0);
        end
        wait_idle(0);
        repeat (60) @(negedge clk);
        chk("ignore_no_second_frame", 32'(busy[0]), 0);

        push_frame(0, 8, 0, 1, 9'h96);
        send(0, 9'h96);
        wait_ticks(3);
        tick_on = 0;
        held_tx = tx[0];
        c = 0;
        repeat (30) begin
            @(negedge clk);
            if (tx[0] !== held_tx || busy[0] !== 1'b1) c++;
        end
        chk("no_tick_hold", c, 0);
        @(posedge clk);
        tick_on = 1;
        wait_idle(0);

        push_frame(0, 8, 0, 1, 9'hC3);
        send(0, 9'hC3);
        wait_ticks(4);
        @(negedge clk);
        chk("pre_reset_tx_low", 32'(tx[0]), 0);
        rst_n = 0;
        #1;
        chk("async_reset_tx", 32'(tx[0]), 1);
        chk("async_reset_ready", 32'(ready[0]), 1);
        chk("async_reset_busy", 32'(busy[0]), 0);
        q[0].delete();
        repeat (3) @(negedge clk);
        rst_n = 1;
        push_frame(0, 8, 0, 1, 9'h81);
        send(0, 9'h81);
        wait_idle(0);

        repeat (80) @(negedge clk);
        for (int k = 0; k < 3; k++) chk($sformatf("final_queue_empty_dut%0d", k), q[k].size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
